tap_sequencer: RTL and testbench
================================

Name: tap_sequencer

Overview:
- IEEE 1149.1-style TAP controller that sequences the JTAG test datapath.
- Runs the 16-state TAP FSM from TMS and holds the instruction register, plus the internal BYPASS and IDCODE data registers.
- Produces the pre-retimed serial output G2_TDO and its enable. The downstream falling-edge output latch retimes both onto TDO.
- Issues capture/shift/update strobes to one external data chain.

Parameters:
- IR_WIDTH, 4, instruction register length (minimum 2).
- IDCODE_VAL, 32'h1000_0001, value captured into IDCODE register (bit 0 must be 1).
- OP_EXTEST, 4'h0, opcode selecting external chain (EXTEST).
- OP_IDCODE, 4'h1, opcode selecting IDCODE register.
- OP_SAMPLE, 4'h2, opcode selecting external chain (SAMPLE/PRELOAD).

Ports:
- TCK  input  1  test clock; all state changes on rising edge.
- TRST_N  input  1  asynchronous active-low test reset.
- TMS  input  1  mode select, sampled on TCK rise.
- TDI  input  1  serial data in.
- DR_TDO  input  1  serial return from external data chain.
- G2_TDO  output  1  serial data to output latch (pre-retime).
- TDO_EN_PRE  output  1  output enable to latch; high in Shift-IR/Shift-DR.
- STATE  output  4  current TAP state encoding.
- IR_OUT  output  IR_WIDTH  active (updated) instruction.
- SEL_EXT  output  1  IR_OUT is OP_EXTEST or OP_SAMPLE.
- CAPTURE_DR  output  1  Capture-DR and SEL_EXT.
- SHIFT_DR  output  1  Shift-DR and SEL_EXT.
- UPDATE_DR  output  1  Update-DR and SEL_EXT.
- TLR  output  1  high in Test-Logic-Reset.

Behaviour:
- Reset (TRST_N low, async):
  - state = Test-Logic-Reset (4'hF).
  - IR_OUT = OP_IDCODE; IR shift reg = 0.
  - bypass = 0; IDCODE shift reg = IDCODE_VAL.
  - All strobes and TDO_EN_PRE low; G2_TDO = 0.
- State encoding (hex): TLR F, RTI C, SelDR 7, CapDR 6, ShDR 2, Ex1DR 1, PauseDR 3, Ex2DR 0, UpdDR 5, SelIR 4, CapIR E, ShIR A, Ex1IR 9, PauseIR B, Ex2IR 8, UpdIR D.
- Transitions, given as TMS=0 / TMS=1:
  - TLR: RTI / TLR.
  - RTI: RTI / SelDR.
  - SelDR: CapDR / SelIR.
  - SelIR: CapIR / TLR.
  - CapXR: ShXR / Ex1XR.
  - ShXR: ShXR / Ex1XR.
  - Ex1XR: PauseXR / UpdXR.
  - PauseXR: PauseXR / Ex2XR.
  - Ex2XR: ShXR / UpdXR.
  - UpdXR: RTI / SelDR.
- Five consecutive TMS=1 edges reach TLR from any state.
- While state = TLR, IR_OUT is held at OP_IDCODE on every edge.
- IR, on the rising edge while in:
  - CapIR: shift reg loads {0..0,0,1} (bit0=1, bit1=0).
  - ShIR: shift right, TDI into MSB.
  - UpdIR: IR_OUT loads shift reg.
- DR selection by IR_OUT:
  - OP_IDCODE selects IDCODE.
  - OP_EXTEST or OP_SAMPLE selects external (SEL_EXT=1).
  - Any other opcode, including all-ones, selects BYPASS.
- DR, on the rising edge while in:
  - CapDR: bypass loads 0; IDCODE reg loads IDCODE_VAL (only the selected register acts).
  - ShDR: bypass <= TDI; IDCODE reg shifts right with TDI into MSB.
  - UpdDR: no internal effect.
- External chain behaviour is owned downstream and driven only via the strobes.
- G2_TDO is a combinational decode of the state and registers:
  - ShIR: IR shift reg bit0.
  - ShDR: LSB of selected register (bypass, IDCODE bit0, or DR_TDO).
  - Otherwise 0.
- TDO_EN_PRE = (state==ShIR) or (state==ShDR).
- Zero latency from the state register. The falling-edge latch adds the half-cycle.
- CAPTURE_DR, SHIFT_DR and UPDATE_DR are decodes of the registered state: one clean high level per state visit, never high together.
- TRST_N asserted mid-shift:
  - Immediate return to TLR; a partial IR shift is discarded and IR_OUT = OP_IDCODE.
  - No UPDATE_DR pulse is issued.
- Async assert, synchronous-safe deassert. TMS is sampled at the first TCK rise after release.

Optional Feature:
- Macro TAP_IDCODE_EN.
- Defined: IDCODE register present. Reset/TLR instruction is OP_IDCODE.
- Undefined: IDCODE register is not built; OP_IDCODE decodes as BYPASS. Reset/TLR instruction is all-ones (BYPASS), so a fresh Shift-DR returns a single 0 followed by TDI delayed by one TCK.

Test Plan:
- TRST_N low in ShDR → STATE=4'hF, IR_OUT=OP_IDCODE, TDO_EN_PRE=0 with no TCK edge.
- From RTI, apply TMS=1 ×5 → STATE=4'hF. TMS 0,1,0,0 → STATE sequence C,7,6,2.
- After reset, TMS 0,1,0,0 then 32 ShDR edges → G2_TDO serially gives 32'h1000_0001 LSB first, TDO_EN_PRE=1 throughout.
- Enter ShIR → first G2_TDO bits 1,0,0,0. Shift in 4'hF, UpdIR → IR_OUT=4'hF, SEL_EXT=0.
- With BYPASS, ShDR with TDI 1,0,1,1 → G2_TDO 0,1,0,1 (one-cycle delay).
- Load OP_SAMPLE, walk CapDR→ShDR×3→Ex1DR→UpdDR:
  - CAPTURE_DR high 1 cycle, SHIFT_DR high 3 cycles, UPDATE_DR high 1 cycle.
  - G2_TDO follows DR_TDO in ShDR.
- Compile without TAP_IDCODE_EN: reset then ShDR → G2_TDO 0, then TDI delayed one TCK.

Source files
------------

// File: rtl/tap_sequencer_if.sv
// Signal bundle between the TAP sequencer and its surroundings.
// The sequencer uses the slave modport; a driver or pad ring uses master.
// The port names follow the established pin names of the test datapath.
interface tap_sequencer_if #(
  parameter int IR_WIDTH = 4
);
  logic                TMS;
  logic                TDI;
  logic                DR_TDO;
  logic                G2_TDO;
  logic                TDO_EN_PRE;
  logic [3:0]          STATE;
  logic [IR_WIDTH-1:0] IR_OUT;
  logic                SEL_EXT;
  logic                CAPTURE_DR;
  logic                SHIFT_DR;
  logic                UPDATE_DR;
  logic                TLR;

  modport master (
    output TMS, TDI, DR_TDO,
    input  G2_TDO, TDO_EN_PRE, STATE, IR_OUT, SEL_EXT,
           CAPTURE_DR, SHIFT_DR, UPDATE_DR, TLR
  );

  modport slave (
    input  TMS, TDI, DR_TDO,
    output G2_TDO, TDO_EN_PRE, STATE, IR_OUT, SEL_EXT,
           CAPTURE_DR, SHIFT_DR, UPDATE_DR, TLR
  );
endinterface

// File: rtl/tap_sequencer.sv
// IEEE 1149.1-style TAP controller: 16-state TAP FSM, instruction register,
// BYPASS and (optionally) IDCODE data registers, plus capture/shift/update
// strobes for one external data chain.
//
// Optional feature macro: TAP_IDCODE_EN
//   defined   - IDCODE register built; reset/TLR instruction is OP_IDCODE.
//   undefined - no IDCODE register; OP_IDCODE decodes as BYPASS and the
//               reset/TLR instruction is all-ones (BYPASS).
//
// G2_TDO and TDO_EN_PRE are pure decodes of registered state; the
// downstream falling-edge latch supplies the half-cycle retiming onto TDO.
//
// TRST_N is applied directly (no synchroniser) so TMS is sampled at the very
// first TCK rise after release. Deassertion is safe because the FSM only
// leaves TLR on TMS=0, which the protocol holds stable around release.
//
// state   | meaning
// --------+---------------------------------------------
// S_TLR   | Test-Logic-Reset, IR forced to reset opcode
// S_RTI   | Run-Test/Idle
// S_SELDR | Select-DR-Scan
// S_CAPDR | Capture-DR, selected DR loads
// S_SHDR  | Shift-DR, selected DR shifts TDI in
// S_EX1DR | Exit1-DR
// S_PSDR  | Pause-DR
// S_EX2DR | Exit2-DR
// S_UPDDR | Update-DR
// S_SELIR | Select-IR-Scan
// S_CAPIR | Capture-IR, IR shift reg loads ...01
// S_SHIR  | Shift-IR
// S_EX1IR | Exit1-IR
// S_PSIR  | Pause-IR
// S_EX2IR | Exit2-IR
// S_UPDIR | Update-IR, IR_OUT loads IR shift reg
module tap_sequencer #(
  parameter int                  IR_WIDTH   = 4,
  parameter logic [31:0]         IDCODE_VAL = 32'h1000_0001,
  parameter logic [IR_WIDTH-1:0] OP_EXTEST  = 'h0,
  parameter logic [IR_WIDTH-1:0] OP_IDCODE  = 'h1,
  parameter logic [IR_WIDTH-1:0] OP_SAMPLE  = 'h2
) (
  input  logic           TCK,
  input  logic           TRST_N,
  tap_sequencer_if.slave tap
);

  typedef enum logic [3:0] {
    S_TLR   = 4'hF,
    S_RTI   = 4'hC,
    S_SELDR = 4'h7,
    S_CAPDR = 4'h6,
    S_SHDR  = 4'h2,
    S_EX1DR = 4'h1,
    S_PSDR  = 4'h3,
    S_EX2DR = 4'h0,
    S_UPDDR = 4'h5,
    S_SELIR = 4'h4,
    S_CAPIR = 4'hE,
    S_SHIR  = 4'hA,
    S_EX1IR = 4'h9,
    S_PSIR  = 4'hB,
    S_EX2IR = 4'h8,
    S_UPDIR = 4'hD
  } tap_state_e;

`ifdef TAP_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] RESET_IR = OP_IDCODE;
`else
  localparam logic [IR_WIDTH-1:0] RESET_IR = {IR_WIDTH{1'b1}};
`endif

  // Capture pattern is ...0001 so a scan of the IR chain finds its boundary.
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = {{(IR_WIDTH-1){1'b0}}, 1'b1};

  tap_state_e          state;
  tap_state_e          next_state;
  logic [IR_WIDTH-1:0] ir_shift;
  logic [IR_WIDTH-1:0] ir_out;
  logic                bypass_reg;
  logic                sel_ext;
  logic                sel_idcode;
  logic                idcode_lsb;

  assign sel_ext = (ir_out == OP_EXTEST) || (ir_out == OP_SAMPLE);

`ifdef TAP_IDCODE_EN
  logic [31:0] idcode_reg;

  assign sel_idcode = (ir_out == OP_IDCODE) && !sel_ext;
  assign idcode_lsb = idcode_reg[0];

  // IDCODE register: capture the fixed ID, shift it out LSB first.
  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      idcode_reg <= IDCODE_VAL;
    end else if (sel_idcode) begin
      if (state == S_CAPDR) begin
        idcode_reg <= IDCODE_VAL;
      end else if (state == S_SHDR) begin
        idcode_reg <= {tap.TDI, idcode_reg[31:1]};
      end
    end
  end
`else
  logic unused_cfg;

  assign sel_idcode = 1'b0;
  assign idcode_lsb = 1'b0;
  assign unused_cfg = ^{IDCODE_VAL, OP_IDCODE};
`endif

  // TAP state register.
  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      state <= S_TLR;
    end else begin
      state <= next_state;
    end
  end

  // TAP next-state decode from TMS.
  always_comb begin
    next_state = S_TLR;
    case (state)
      S_TLR:   next_state = tap.TMS ? S_TLR   : S_RTI;
      S_RTI:   next_state = tap.TMS ? S_SELDR : S_RTI;
      S_SELDR: next_state = tap.TMS ? S_SELIR : S_CAPDR;
      S_CAPDR: next_state = tap.TMS ? S_EX1DR : S_SHDR;
      S_SHDR:  next_state = tap.TMS ? S_EX1DR : S_SHDR;
      S_EX1DR: next_state = tap.TMS ? S_UPDDR : S_PSDR;
      S_PSDR:  next_state = tap.TMS ? S_EX2DR : S_PSDR;
      S_EX2DR: next_state = tap.TMS ? S_UPDDR : S_SHDR;
      S_UPDDR: next_state = tap.TMS ? S_SELDR : S_RTI;
      S_SELIR: next_state = tap.TMS ? S_TLR   : S_CAPIR;
      S_CAPIR: next_state = tap.TMS ? S_EX1IR : S_SHIR;
      S_SHIR:  next_state = tap.TMS ? S_EX1IR : S_SHIR;
      S_EX1IR: next_state = tap.TMS ? S_UPDIR : S_PSIR;
      S_PSIR:  next_state = tap.TMS ? S_EX2IR : S_PSIR;
      S_EX2IR: next_state = tap.TMS ? S_UPDIR : S_SHIR;
      S_UPDIR: next_state = tap.TMS ? S_SELDR : S_RTI;
      default: next_state = S_TLR;
    endcase
  end

  // Instruction register: capture/shift chain plus the active instruction.
  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      ir_shift <= '0;
      ir_out   <= RESET_IR;
    end else begin
      case (state)
        S_CAPIR: ir_shift <= IR_CAPTURE;
        S_SHIR:  ir_shift <= {tap.TDI, ir_shift[IR_WIDTH-1:1]};
        S_UPDIR: ir_out   <= ir_shift;
        S_TLR:   ir_out   <= RESET_IR;
        default: ;
      endcase
    end
  end

  // BYPASS register: single stage, cleared on capture.
  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      bypass_reg <= 1'b0;
    end else if (!sel_ext && !sel_idcode) begin
      if (state == S_CAPDR) begin
        bypass_reg <= 1'b0;
      end else if (state == S_SHDR) begin
        bypass_reg <= tap.TDI;
      end
    end
  end

  // Output decode: serial data, enable and chain strobes from registered state.
  always_comb begin
    tap.G2_TDO     = 1'b0;
    tap.TDO_EN_PRE = 1'b0;
    tap.CAPTURE_DR = 1'b0;
    tap.SHIFT_DR   = 1'b0;
    tap.UPDATE_DR  = 1'b0;
    case (state)
      S_SHIR: begin
        tap.G2_TDO     = ir_shift[0];
        tap.TDO_EN_PRE = 1'b1;
      end
      S_SHDR: begin
        tap.TDO_EN_PRE = 1'b1;
        tap.SHIFT_DR   = sel_ext;
        if (sel_ext) begin
          tap.G2_TDO = tap.DR_TDO;
        end else if (sel_idcode) begin
          tap.G2_TDO = idcode_lsb;
        end else begin
          tap.G2_TDO = bypass_reg;
        end
      end
      S_CAPDR: tap.CAPTURE_DR = sel_ext;
      S_UPDDR: tap.UPDATE_DR  = sel_ext;
      default: ;
    endcase
  end

  assign tap.STATE   = state;
  assign tap.IR_OUT  = ir_out;
  assign tap.SEL_EXT = sel_ext;
  assign tap.TLR     = (state == S_TLR);

endmodule

// File: tb/tb_tap_sequencer.sv
// Directed bench for tap_sequencer. Expectations adapt to TAP_IDCODE_EN.
module tb_tap_sequencer;

  localparam logic [3:0]  OP_EXTEST  = 4'h0;
  localparam logic [3:0]  OP_IDCODE  = 4'h1;
  localparam logic [3:0]  OP_SAMPLE  = 4'h2;
  localparam logic [31:0] IDCODE_EXP = 32'h1000_0001;
`ifdef TAP_IDCODE_EN
  localparam logic [3:0]  RST_IR     = 4'h1;
`else
  localparam logic [3:0]  RST_IR     = 4'hF;
`endif

  logic tck;
  logic trst_n;
  int   n_cmp;
  int   n_err;

  tap_sequencer_if #(.IR_WIDTH(4)) tif ();

  tap_sequencer #(
    .IR_WIDTH   (4),
    .IDCODE_VAL (IDCODE_EXP),
    .OP_EXTEST  (OP_EXTEST),
    .OP_IDCODE  (OP_IDCODE),
    .OP_SAMPLE  (OP_SAMPLE)
  ) dut (
    .TCK    (tck),
    .TRST_N (trst_n),
    .tap    (tif)
  );

  initial tck = 1'b0;
  always #5 tck = ~tck;

  initial begin
    #200000;
    $display("FAIL watchdog: run time limit reached before summary");
    $fatal(1, "watchdog");
  end

  // Drive TMS/TDI on the falling edge, then sample 1 time unit after the rise.
  task automatic tick(input logic tms, input logic tdi);
    @(negedge tck);
    tif.TMS = tms;
    tif.TDI = tdi;
    @(posedge tck);
    #1;
  endtask

  task automatic chk_state(input string name, input logic [3:0] exp);
    n_cmp++;
    if (tif.STATE !== exp) begin
      n_err++;
      $display("FAIL %s: STATE got %h want %h", name, tif.STATE, exp);
    end
  endtask

  task automatic test_reset;
    trst_n     = 1'b1;
    tif.TMS    = 1'b1;
    tif.TDI    = 1'b0;
    tif.DR_TDO = 1'b0;
    #2 trst_n = 1'b0;
    repeat (2) @(posedge tck);
    #1;
    chk_state("reset_state", 4'hF);
    n_cmp++;
    if (tif.IR_OUT !== RST_IR) begin
      n_err++; $display("FAIL reset_ir: got %h want %h", tif.IR_OUT, RST_IR);
    end
    n_cmp++;
    if ({tif.G2_TDO, tif.TDO_EN_PRE, tif.CAPTURE_DR, tif.SHIFT_DR, tif.UPDATE_DR} !== 5'b0) begin
      n_err++; $display("FAIL reset_outs: got %b want 00000",
        {tif.G2_TDO, tif.TDO_EN_PRE, tif.CAPTURE_DR, tif.SHIFT_DR, tif.UPDATE_DR});
    end
    n_cmp++;
    if (tif.TLR !== 1'b1) begin
      n_err++; $display("FAIL reset_tlr: got %b want 1", tif.TLR);
    end
    @(negedge tck);
    tif.TMS = 1'b1;
    trst_n  = 1'b1;
  endtask

  task automatic test_tms_walk;
    logic [3:0] exp_seq [4];
    logic       tms_seq [4];
    exp_seq = '{4'hC, 4'h7, 4'h6, 4'h2};
    tms_seq = '{1'b0, 1'b1, 1'b0, 1'b0};
    tick(1'b0, 1'b0);
    chk_state("walk_rti", 4'hC);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
    chk_state("walk_five_ones", 4'hF);
    for (int i = 0; i < 4; i++) begin
      tick(tms_seq[i], 1'b0);
      chk_state($sformatf("walk_seq%0d", i), exp_seq[i]);
    end
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
    chk_state("walk_back_tlr", 4'hF);
  endtask

  // Assumes STATE = Shift-DR with BYPASS selected; leaves in Run-Test/Idle.
  task automatic shift_bypass(input string name);
    logic d   [4];
    logic exp [4];
    d   = '{1'b1, 1'b0, 1'b1, 1'b1};
    exp = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (tif.G2_TDO !== exp[i] || tif.TDO_EN_PRE !== 1'b1 || tif.SHIFT_DR !== 1'b0) begin
        n_err++;
        $display("FAIL %s bit%0d: g2/en/shift got %b%b%b want %b10", name, i,
                 tif.G2_TDO, tif.TDO_EN_PRE, tif.SHIFT_DR, exp[i]);
      end
      tick(1'b0, d[i]);
    end
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    chk_state({name, "_exit"}, 4'hC);
  endtask

  task automatic test_default_dr;
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    chk_state("dr_enter_shdr", 4'h2);
`ifdef TAP_IDCODE_EN
    for (int i = 0; i < 32; i++) begin
      n_cmp++;
      if (tif.G2_TDO !== IDCODE_EXP[i] || tif.TDO_EN_PRE !== 1'b1) begin
        n_err++;
        $display("FAIL idcode bit%0d: g2/en got %b%b want %b1", i,
                 tif.G2_TDO, tif.TDO_EN_PRE, IDCODE_EXP[i]);
      end
      tick(i == 31, 1'b0);
    end
    n_cmp++;
    if (tif.TDO_EN_PRE !== 1'b0 || tif.STATE !== 4'h1) begin
      n_err++; $display("FAIL idcode_exit: en/state got %b/%h want 0/1", tif.TDO_EN_PRE, tif.STATE);
    end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    chk_state("idcode_rti", 4'hC);
`else
    shift_bypass("default_bypass");
`endif
  endtask

  // From Run-Test/Idle: load an instruction and return to Run-Test/Idle.
  task automatic load_ir(input logic [3:0] op, input logic exp_ext);
    logic [3:0] cap;
    cap = 4'b0001;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    chk_state("ir_enter_shir", 4'hA);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (tif.G2_TDO !== cap[i] || tif.TDO_EN_PRE !== 1'b1) begin
        n_err++;
        $display("FAIL ir_capture bit%0d: g2/en got %b%b want %b1", i,
                 tif.G2_TDO, tif.TDO_EN_PRE, cap[i]);
      end
      tick(i == 3, op[i]);
    end
    tick(1'b1, 1'b0);
    chk_state("ir_updir", 4'hD);
    tick(1'b0, 1'b0);
    n_cmp++;
    if (tif.IR_OUT !== op || tif.SEL_EXT !== exp_ext || tif.STATE !== 4'hC) begin
      n_err++;
      $display("FAIL ir_load: ir/sel/state got %h/%b/%h want %h/%b/c",
               tif.IR_OUT, tif.SEL_EXT, tif.STATE, op, exp_ext);
    end
  endtask

  task automatic test_bypass;
    load_ir(4'hF, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    n_cmp++;
    if (tif.CAPTURE_DR !== 1'b0) begin
      n_err++; $display("FAIL bypass_no_capture: got %b want 0", tif.CAPTURE_DR);
    end
    tick(1'b0, 1'b0);
    chk_state("bypass_shdr", 4'h2);
    shift_bypass("ir_bypass");
`ifndef TAP_IDCODE_EN
    load_ir(OP_IDCODE, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    shift_bypass("idcode_as_bypass");
`endif
  endtask

  task automatic test_sample_strobes;
    logic pat [3];
    pat = '{1'b1, 1'b0, 1'b1};
    load_ir(OP_EXTEST, 1'b1);
    load_ir(OP_SAMPLE, 1'b1);
    tick(1'b1, 1'b0);
    n_cmp++;
    if ({tif.CAPTURE_DR, tif.SHIFT_DR, tif.UPDATE_DR} !== 3'b000) begin
      n_err++; $display("FAIL strobe_seldr: got %b want 000", {tif.CAPTURE_DR, tif.SHIFT_DR, tif.UPDATE_DR});
    end
    tick(1'b0, 1'b0);
    n_cmp++;
    if ({tif.CAPTURE_DR, tif.SHIFT_DR, tif.UPDATE_DR} !== 3'b100) begin
      n_err++; $display("FAIL strobe_capdr: got %b want 100", {tif.CAPTURE_DR, tif.SHIFT_DR, tif.UPDATE_DR});
    end
    tick(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tif.DR_TDO = pat[i];
      #1;
      n_cmp++;
      if (tif.G2_TDO !== pat[i] || {tif.CAPTURE_DR, tif.SHIFT_DR, tif.UPDATE_DR} !== 3'b010) begin
        n_err++;
        $display("FAIL strobe_shdr%0d: g2/strobes got %b/%b want %b/010", i, tif.G2_TDO,
                 {tif.CAPTURE_DR, tif.SHIFT_DR, tif.UPDATE_DR}, pat[i]);
      end
      tick(i == 2, 1'b0);
    end
    tif.DR_TDO = 1'b1;
    #1;
    n_cmp++;
    if ({tif.CAPTURE_DR, tif.SHIFT_DR, tif.UPDATE_DR, tif.G2_TDO} !== 4'b0000 || tif.STATE !== 4'h1) begin
      n_err++; $display("FAIL strobe_ex1dr: strobes+g2/state got %b/%h want 0000/1",
        {tif.CAPTURE_DR, tif.SHIFT_DR, tif.UPDATE_DR, tif.G2_TDO}, tif.STATE);
    end
    tick(1'b1, 1'b0);
    n_cmp++;
    if ({tif.CAPTURE_DR, tif.SHIFT_DR, tif.UPDATE_DR} !== 3'b001) begin
      n_err++; $display("FAIL strobe_upddr: got %b want 001", {tif.CAPTURE_DR, tif.SHIFT_DR, tif.UPDATE_DR});
    end
    tick(1'b0, 1'b0);
    n_cmp++;
    if (tif.UPDATE_DR !== 1'b0 || tif.STATE !== 4'hC) begin
      n_err++; $display("FAIL strobe_rti: upd/state got %b/%h want 0/c", tif.UPDATE_DR, tif.STATE);
    end
    tif.DR_TDO = 1'b0;
  endtask

  task automatic test_tlr_hold;
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
    n_cmp++;
    if (tif.STATE !== 4'hF || tif.IR_OUT !== RST_IR || tif.SEL_EXT !== 1'b0 || tif.TLR !== 1'b1) begin
      n_err++; $display("FAIL tlr_hold: state/ir/sel/tlr got %h/%h/%b/%b want f/%h/0/1",
        tif.STATE, tif.IR_OUT, tif.SEL_EXT, tif.TLR, RST_IR);
    end
  endtask

  task automatic test_trst_mid_shift;
    tick(1'b0, 1'b0);
    load_ir(OP_SAMPLE, 1'b1);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    n_cmp++;
    if (tif.SHIFT_DR !== 1'b1 || tif.STATE !== 4'h2) begin
      n_err++; $display("FAIL trst_pre: shift/state got %b/%h want 1/2", tif.SHIFT_DR, tif.STATE);
    end
    trst_n = 1'b0;
    #1;
    chk_state("trst_state", 4'hF);
    n_cmp++;
    if (tif.IR_OUT !== RST_IR || tif.TDO_EN_PRE !== 1'b0 || tif.SHIFT_DR !== 1'b0 || tif.UPDATE_DR !== 1'b0) begin
      n_err++; $display("FAIL trst_outs: ir/en/shift/upd got %h/%b/%b/%b want %h/0/0/0",
        tif.IR_OUT, tif.TDO_EN_PRE, tif.SHIFT_DR, tif.UPDATE_DR, RST_IR);
    end
    @(negedge tck);
    tif.TMS = 1'b1;
    trst_n  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0);
      n_cmp++;
      if (tif.UPDATE_DR !== 1'b0 || tif.STATE !== 4'hF) begin
        n_err++; $display("FAIL trst_after%0d: upd/state got %b/%h want 0/f", i, tif.UPDATE_DR, tif.STATE);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_tms_walk();
    test_default_dr();
    test_bypass();
    test_sample_strobes();
    test_tlr_hold();
    test_trst_mid_shift();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
